// File: rtl/pe_seq_pkg.sv
// Shared types for the PE micro-op sequencer: FSM states and the uop word.
// Pure type/constant package, no logic, no latency.
// No flow control here; consumers handle backpressure.
`ifndef PE_DEFINES_SV
`include "defines.sv"
`endif

package pe_seq_pkg;

    localparam int XLEN = `XLEN;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        BIAS,
        RELU,
        FLUSH,
        WAIT_RES
    } state_t;

    // One PE micro-op as driven on the pe_* pins.
    typedef struct packed {
        logic            in_valid;
        logic            calc_bias;
        logic            calc_relu;
        logic            out_en;
        logic            flush;
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] weight;
    } pe_uop_t;

endpackage

// File: rtl/defines.sv
`ifndef PE_DEFINES_SV
`define PE_DEFINES_SV
`define XLEN 32
`define DATA_RANGE `XLEN-1:0
`endif

// File: rtl/pe_seq_res_buf.sv
// One-entry valid/ready holding register for the PE result.
// Latency: 1 cycle from push to pop_vld.
// Backpressure: pop_dat held stable while pop_vld & !pop_rdy; push only when empty.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push_vld, push_dat  write a result (caller guarantees the entry is empty)
//   pop_vld, pop_rdy    downstream valid/ready handshake
//   pop_dat             held result
//   empty               entry free
module pe_seq_res_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         empty
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_vld <= 1'b0;
            pop_dat <= '0;
        end else if (push_vld) begin
            pop_vld <= 1'b1;
            pop_dat <= push_dat;
        end else if (pop_vld && pop_rdy) begin
            pop_vld <= 1'b0;
        end
    end

    assign empty = !pop_vld;

endmodule

// File: rtl/pe_uop_sequencer.sv
// Drives one PE through MAC..MAC, [BIAS], [RELU], FLUSH per job and returns its result.
// Latency: uops registered, 1 cycle after the operand handshake / state; result 1 cycle after capture.
// Backpressure: one job in flight; job_ready drops until the result has been taken downstream.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   job_*                           descriptor valid/ready: num_mac, bias/relu flags, bias operand
//   opd_*                           x/weight operand stream valid/ready
//   pe_in_valid .. pe_weight        registered uop fields to the PE
//   pe_result, pe_out_valid         PE result pulse
//   pe_illegal_uop                  PE error flag
//   res_valid, res_ready, res_data  result stream
//   err_sticky                      illegal uop, zero num_mac or result timeout; cleared by rst
// Build option: PE_SEQ_TIMEOUT_EN adds a RES_TIMEOUT-cycle limit on waiting for the result.
module pe_uop_sequencer
    import pe_seq_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int RES_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [CNT_W-1:0] job_num_mac,
    input  logic             job_bias,
    input  logic             job_relu,
    input  logic [XLEN-1:0]  job_bias_val,
    input  logic             opd_valid,
    output logic             opd_ready,
    input  logic [XLEN-1:0]  opd_x,
    input  logic [XLEN-1:0]  opd_w,
    output logic             pe_in_valid,
    output logic             pe_calc_bias,
    output logic             pe_calc_relu,
    output logic             pe_out_en,
    output logic             pe_flush,
    output logic [XLEN-1:0]  pe_x,
    output logic [XLEN-1:0]  pe_weight,
    input  logic [XLEN-1:0]  pe_result,
    input  logic             pe_out_valid,
    input  logic             pe_illegal_uop,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic             err_sticky
);

    state_t            state_q, state_d;
    pe_uop_t           uop_q, uop_d;
    logic [CNT_W-1:0]  num_mac_q;
    logic [CNT_W-1:0]  mac_cnt_q;
    logic              bias_q, relu_q;
    logic [XLEN-1:0]   bias_val_q;
    logic              got_res_q;
    logic [XLEN-1:0]   hold_q;
    logic              err_q;

    logic              job_acc, opd_acc, mac_last;
    logic              push_vld;
    logic [XLEN-1:0]   push_dat;
    logic              buf_empty;
    logic              tmo_hit;

    // Ready outputs are forced low while rst is high so nothing is accepted in the reset cycle.
    assign job_ready = !rst && (state_q == IDLE) && buf_empty;
    assign opd_ready = !rst && (state_q == MAC);
    assign job_acc   = job_valid && job_ready;
    assign opd_acc   = opd_valid && opd_ready;
    assign mac_last  = (mac_cnt_q == num_mac_q - CNT_W'(1));

`ifdef PE_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(RES_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != WAIT_RES) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    // No timeout in this build; the parameter is only kept for a uniform interface.
    logic [31:0] unused_tmo_cfg;
    assign unused_tmo_cfg = RES_TIMEOUT;
`endif

    always_comb begin
        state_d  = state_q;
        uop_d    = '0;
        push_vld = 1'b0;
        push_dat = got_res_q ? hold_q : pe_result;
        tmo_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (job_acc && job_num_mac != '0) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (opd_acc) begin
                    uop_d.in_valid = 1'b1;
                    uop_d.x        = opd_x;
                    uop_d.weight   = opd_w;
                    if (mac_last) begin
                        uop_d.out_en = !bias_q && !relu_q;
                        state_d      = bias_q ? BIAS : (relu_q ? RELU : FLUSH);
                    end
                end
            end
            BIAS: begin
                uop_d.in_valid  = 1'b1;
                uop_d.calc_bias = 1'b1;
                uop_d.x         = bias_val_q;
                uop_d.weight    = XLEN'(1);
                uop_d.out_en    = !relu_q;
                state_d         = relu_q ? RELU : FLUSH;
            end
            RELU: begin
                uop_d.calc_relu = 1'b1;
                uop_d.out_en    = 1'b1;
                state_d         = FLUSH;
            end
            FLUSH: begin
                uop_d.flush = 1'b1;
                state_d     = WAIT_RES;
            end
            WAIT_RES: begin
                // The result may already have been captured while FLUSH was still going out.
                if (got_res_q || pe_out_valid) begin
                    push_vld = 1'b1;
                    state_d  = IDLE;
                end
`ifdef PE_SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_W'(RES_TIMEOUT - 1)) begin
                    push_vld = 1'b1;
                    push_dat = '0;
                    tmo_hit  = 1'b1;
                    state_d  = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            uop_q      <= '0;
            num_mac_q  <= '0;
            mac_cnt_q  <= '0;
            bias_q     <= 1'b0;
            relu_q     <= 1'b0;
            bias_val_q <= '0;
            got_res_q  <= 1'b0;
            hold_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            uop_q   <= uop_d;

            if (job_acc) begin
                num_mac_q  <= job_num_mac;
                bias_q     <= job_bias;
                relu_q     <= job_relu;
                bias_val_q <= job_bias_val;
                mac_cnt_q  <= '0;
            end else if (state_q == MAC && opd_acc) begin
                // Stops at num_mac, which always fits in CNT_W bits.
                mac_cnt_q <= mac_cnt_q + CNT_W'(1);
            end

            // Early result pulses (during FLUSH or before) are parked until WAIT_RES.
            if (push_vld) begin
                got_res_q <= 1'b0;
            end else if (pe_out_valid && state_q != IDLE && !got_res_q) begin
                got_res_q <= 1'b1;
                hold_q    <= pe_result;
            end

            if (pe_illegal_uop || (job_acc && job_num_mac == '0) || tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    pe_seq_res_buf #(
        .W (XLEN)
    ) u_res_buf (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (res_valid),
        .pop_rdy  (res_ready),
        .pop_dat  (res_data),
        .empty    (buf_empty)
    );

    assign pe_in_valid  = uop_q.in_valid;
    assign pe_calc_bias = uop_q.calc_bias;
    assign pe_calc_relu = uop_q.calc_relu;
    assign pe_out_en    = uop_q.out_en;
    assign pe_flush     = uop_q.flush;
    assign pe_x         = uop_q.x;
    assign pe_weight    = uop_q.weight;
    assign err_sticky   = err_q;

endmodule

// File: tb/tb_pe_uop_sequencer.sv
// Bench for pe_uop_sequencer: a behavioural PE answers the uop stream; each job's
// uop list and result are predicted from the descriptor and operands alone.
module tb_pe_uop_sequencer;
    import pe_seq_pkg::pe_uop_t;

    localparam int XLEN  = pe_seq_pkg::XLEN;
    localparam int CNT_W = 16;
    localparam int RES_TIMEOUT = 64;

    typedef logic signed [XLEN-1:0] sdat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             job_valid = 1'b0;
    logic             job_ready;
    logic [CNT_W-1:0] job_num_mac = '0;
    logic             job_bias = 1'b0;
    logic             job_relu = 1'b0;
    logic [XLEN-1:0]  job_bias_val = '0;
    logic             opd_valid = 1'b0;
    logic             opd_ready;
    logic [XLEN-1:0]  opd_x = '0;
    logic [XLEN-1:0]  opd_w = '0;
    logic             pe_in_valid, pe_calc_bias, pe_calc_relu, pe_out_en, pe_flush;
    logic [XLEN-1:0]  pe_x, pe_weight;
    logic [XLEN-1:0]  pe_result = '0;
    logic             pe_out_valid = 1'b0;
    logic             pe_illegal_uop = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [XLEN-1:0]  res_data;
    logic             err_sticky;

    pe_uop_sequencer #(
        .CNT_W       (CNT_W),
        .RES_TIMEOUT (RES_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_num_mac    (job_num_mac),
        .job_bias       (job_bias),
        .job_relu       (job_relu),
        .job_bias_val   (job_bias_val),
        .opd_valid      (opd_valid),
        .opd_ready      (opd_ready),
        .opd_x          (opd_x),
        .opd_w          (opd_w),
        .pe_in_valid    (pe_in_valid),
        .pe_calc_bias   (pe_calc_bias),
        .pe_calc_relu   (pe_calc_relu),
        .pe_out_en      (pe_out_en),
        .pe_flush       (pe_flush),
        .pe_x           (pe_x),
        .pe_weight      (pe_weight),
        .pe_result      (pe_result),
        .pe_out_valid   (pe_out_valid),
        .pe_illegal_uop (pe_illegal_uop),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .err_sticky     (err_sticky)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Operands of the current job and everything the PE saw.
    sdat_t   xs[$];
    sdat_t   ws[$];
    pe_uop_t obs[$];
    int      bad_shape = 0;
    bit      pe_silent = 1'b0;

    // Behavioural PE: accumulates, answers out_en with a result pulse 0..3 cycles later.
    initial begin : pe_model
        pe_uop_t u;
        sdat_t   acc;
        sdat_t   snap;
        int      pend;
        acc  = '0;
        snap = '0;
        pend = -1;
        forever begin
            @(negedge clk);
            pe_out_valid = 1'b0;
            if (rst) begin
                acc  = '0;
                pend = -1;
            end else begin
                u.in_valid  = pe_in_valid;
                u.calc_bias = pe_calc_bias;
                u.calc_relu = pe_calc_relu;
                u.out_en    = pe_out_en;
                u.flush     = pe_flush;
                u.x         = pe_x;
                u.weight    = pe_weight;
                if (u.in_valid || u.calc_bias || u.calc_relu || u.out_en || u.flush) begin
                    obs.push_back(u);
                    if ((int'(u.in_valid) + int'(u.calc_relu) + int'(u.flush)) != 1 ||
                        (u.calc_bias && !u.in_valid) || (u.flush && u.out_en))
                        bad_shape++;
                end
                if (u.in_valid) acc = acc + sdat_t'(u.x) * sdat_t'(u.weight);
                if (u.calc_relu && acc < 0) acc = '0;
                if (u.out_en) begin
                    snap = acc;
                    pend = $urandom_range(0, 3);
                end
                if (u.flush) acc = '0;
                if (pend == 0) begin
                    if (!pe_silent) begin
                        pe_out_valid = 1'b1;
                        pe_result    = snap;
                    end
                    pend = -1;
                end else if (pend > 0) begin
                    pend--;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic fill_const(input int n, input sdat_t x, input sdat_t w);
        xs.delete();
        ws.delete();
        for (int i = 0; i < n; i++) begin
            xs.push_back(x);
            ws.push_back(w);
        end
    endtask

    task automatic fill_rand(input int n);
        xs.delete();
        ws.delete();
        for (int i = 0; i < n; i++) begin
            xs.push_back(sdat_t'(int'($urandom_range(0, 16)) - 8));
            ws.push_back(sdat_t'(int'($urandom_range(0, 16)) - 8));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Returns at posedge+1 of the cycle after the handshake.
    task automatic drive_job(input int n, input bit b, input bit r, input sdat_t bv);
        bit done;
        int t;
        done = 1'b0;
        t = 0;
        @(posedge clk); #1;
        job_valid    = 1'b1;
        job_num_mac  = n[CNT_W-1:0];
        job_bias     = b;
        job_relu     = r;
        job_bias_val = bv;
        while (!done && t < 100) begin
            @(negedge clk);
            done = job_ready;
            @(posedge clk); #1;
            t++;
        end
        job_valid = 1'b0;
        if (!done) chk("job_accept", 0, 1);
    endtask

    // mode 0: always valid, 1: valid every other cycle, 2: random gaps.
    task automatic send_opds(input int n, input int mode);
        int  i, t;
        bit  hs;
        i = 0;
        t = 0;
        while (i < n && t < 2000) begin
            case (mode)
                0:       opd_valid = 1'b1;
                1:       opd_valid = (t % 2 == 0);
                default: opd_valid = ($urandom_range(0, 2) != 0);
            endcase
            opd_x = xs[i];
            opd_w = ws[i];
            @(negedge clk);
            hs = opd_valid && opd_ready;
            @(posedge clk); #1;
            if (hs) i++;
            t++;
        end
        opd_valid = 1'b0;
        if (i != n) chk("opd_drain", i, n);
    endtask

    task automatic wait_res(output bit ok);
        int t;
        ok = 1'b0;
        t = 0;
        while (!ok && t < 300) begin
            @(negedge clk);
            ok = res_valid;
            t++;
        end
    endtask

    task automatic run_job(input int n, input bit b, input bit r, input sdat_t bv,
                           input int mode, input int hold, input bit exp_err);
        pe_uop_t         exp_q[$];
        pe_uop_t         e;
        sdat_t           er;
        logic [XLEN-1:0] eru;
        logic [XLEN-1:0] d0;
        bit              ok;
        int              nm, serr, bad;

        obs.delete();
        bad_shape = 0;
        er = '0;
        for (int i = 0; i < n; i++) begin
            e = '0;
            e.in_valid = 1'b1;
            e.x        = xs[i];
            e.weight   = ws[i];
            e.out_en   = (i == n - 1) && !b && !r;
            exp_q.push_back(e);
            er = er + xs[i] * ws[i];
        end
        if (b) begin
            e = '0;
            e.in_valid  = 1'b1;
            e.calc_bias = 1'b1;
            e.x         = bv;
            e.weight    = 1;
            e.out_en    = !r;
            exp_q.push_back(e);
            er = er + bv;
        end
        if (r) begin
            e = '0;
            e.calc_relu = 1'b1;
            e.out_en    = 1'b1;
            exp_q.push_back(e);
            if (er < 0) er = '0;
        end
        e = '0;
        e.flush = 1'b1;
        exp_q.push_back(e);

        drive_job(n, b, r, bv);
        send_opds(n, mode);
        wait_res(ok);
        chk("res_seen", ok, 1);
        if (ok) begin
            eru = er;
            chk("res_data", res_data, eru);
            if (hold > 0) begin
                d0  = res_data;
                bad = 0;
                repeat (hold) begin
                    @(negedge clk);
                    if (res_data !== d0 || !res_valid || job_ready) bad++;
                end
                chk("res_hold", bad, 0);
            end
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            @(negedge clk);
            chk("job_ready_after_res", job_ready, 1);
            chk("res_valid_after_res", res_valid, 0);
        end

        nm = 0;
        foreach (obs[i]) if (obs[i].in_valid && !obs[i].calc_bias) nm++;
        chk("n_mac", nm, n);
        serr = (obs.size() != exp_q.size()) ? 1 : 0;
        if (serr == 0) begin
            foreach (exp_q[i]) begin
                if ({obs[i].in_valid, obs[i].calc_bias, obs[i].calc_relu, obs[i].out_en, obs[i].flush} !==
                    {exp_q[i].in_valid, exp_q[i].calc_bias, exp_q[i].calc_relu, exp_q[i].out_en, exp_q[i].flush})
                    serr++;
                else if (exp_q[i].in_valid && (obs[i].x !== exp_q[i].x || obs[i].weight !== exp_q[i].weight))
                    serr++;
            end
        end
        chk("uop_seq", serr, 0);
        chk("uop_shape", bad_shape, 0);
        chk("err_sticky", err_sticky, exp_err);
    endtask

    initial begin : main
        bit ok;

        // Reset state
        @(negedge clk);
        chk("rst_job_ready_in_reset", job_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_job_ready", job_ready, 1);
        chk("rst_opd_ready", opd_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_err", err_sticky, 0);
        chk("rst_uop", {pe_in_valid, pe_calc_bias, pe_calc_relu, pe_out_en, pe_flush}, 0);

        // 32 MACs of 1*1, no flags
        fill_const(32, 1, 1);
        run_job(32, 1'b0, 1'b0, '0, 0, 0, 1'b0);

        // 16 MACs of -1*1, bias 0, relu clamps to 0
        fill_const(16, -1, 1);
        run_job(16, 1'b1, 1'b1, '0, 0, 0, 1'b0);

        // Operand valid toggling, 8 MACs
        fill_rand(8);
        run_job(8, 1'b0, 1'b0, '0, 1, 0, 1'b0);

        // Downstream stalls 20 cycles
        fill_rand(5);
        run_job(5, 1'b1, 1'b0, sdat_t'(-7), 2, 20, 1'b0);

        // Randomized jobs
        repeat (15) begin
            int    n;
            bit    b, r;
            sdat_t bv;
            n  = $urandom_range(1, 12);
            b  = $urandom_range(0, 1);
            r  = $urandom_range(0, 1);
            bv = sdat_t'(int'($urandom_range(0, 40)) - 20);
            fill_rand(n);
            run_job(n, b, r, bv, 2, $urandom_range(0, 3), 1'b0);
        end

        // Reset in the middle of MAC
        fill_rand(10);
        drive_job(10, 1'b0, 1'b1, '0);
        send_opds(3, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_uop", {pe_in_valid, pe_calc_bias, pe_calc_relu, pe_out_en, pe_flush}, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_idle", job_ready, 1);
        chk("midrst_opd_ready", opd_ready, 0);
        fill_rand(4);
        run_job(4, 1'b1, 1'b1, sdat_t'(3), 0, 0, 1'b0);

        // Zero MAC count
        obs.delete();
        drive_job(0, 1'b0, 1'b0, '0);
        repeat (5) @(negedge clk);
        chk("zero_mac_err", err_sticky, 1);
        chk("zero_mac_no_uops", obs.size(), 0);
        chk("zero_mac_idle", job_ready, 1);
        do_reset();
        @(negedge clk);
        chk("err_cleared_by_rst", err_sticky, 0);

        // Illegal-uop flag from the PE; sequencing still works afterwards
        @(posedge clk); #1;
        pe_illegal_uop = 1'b1;
        @(posedge clk); #1;
        pe_illegal_uop = 1'b0;
        @(negedge clk);
        chk("illegal_err", err_sticky, 1);
        fill_rand(6);
        run_job(6, 1'b1, 1'b0, sdat_t'(5), 2, 0, 1'b1);
        do_reset();

`ifdef PE_SEQ_TIMEOUT_EN
        // PE never answers
        pe_silent = 1'b1;
        fill_rand(3);
        drive_job(3, 1'b0, 1'b0, '0);
        send_opds(3, 0);
        wait_res(ok);
        chk("tmo_res_seen", ok, 1);
        chk("tmo_res_data", res_data, 0);
        chk("tmo_err", err_sticky, 1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        pe_silent = 1'b0;
        do_reset();
`endif
        ok = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
